// File: rtl/forex_readback_pkg.sv
// Shared FOREX constants: vertex/predecessor/weight widths, readback FSM states
// and the register map of the path readback slave.
package forex_readback_pkg;
  localparam int VW       = 3;
  localparam int N        = 1 << VW;
  localparam int PRED_W   = VW;
  localparam int WEIGHT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [2:0] ADDR_STATUS = 3'd0;
  localparam logic [2:0] ADDR_POP    = 3'd1;
  localparam logic [2:0] ADDR_START  = 3'd2;
endpackage

// File: rtl/forex_readback_path_fifo.sv
// Path FIFO: show-ahead circular buffer; push when full is dropped, pop when empty ignored.
module path_fifo
  import forex_readback_pkg::*;
#(
  parameter int W     = 3,
  parameter int DEPTH = 9,
  localparam int CW   = $clog2(DEPTH + 1),
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; the pointers alone define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/forex_readback.sv
// Walks the solver predecessor chain from start_vertex until a vertex repeats,
// queueing the path for readback over an Avalon-MM slave.
module forex_readback
  import forex_readback_pkg::*;
#(
  parameter int VW    = forex_readback_pkg::VW,
  parameter int DEPTH = (1 << VW) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          chipselect,
  input  logic          read,
  input  logic [2:0]    address,
  output logic [31:0]   readdata,
  input  logic          start,
  input  logic [VW-1:0] start_vertex,
  output logic [VW-1:0] pred_addr,
  input  logic [VW-1:0] pred_data,
  output logic          busy,
  output logic          irq
);

  localparam int NV = 1 << VW;
  localparam int CW = $clog2(DEPTH + 1);

  state_t          state;
  logic [VW-1:0]   cur;
  logic [VW-1:0]   start_latch;
  logic [NV-1:0]   visited;
  logic            ovf;

  logic            rd_en;
  logic            status_rd;
  logic            launch;
  logic            hit;
  logic            fifo_push;
  logic            fifo_pop;
  logic            fifo_reset;
  logic [VW-1:0]   fifo_din;
  logic [VW-1:0]   fifo_dout;
  logic [CW-1:0]   fifo_count;
  logic            fifo_full;
  logic            fifo_empty;
  logic [VW+1:0]   count_ext;
  logic [31:0]     rd_mux;

  assign rd_en     = chipselect && read;
  assign status_rd = rd_en && (address == ADDR_STATUS);
  assign fifo_pop  = rd_en && (address == ADDR_POP);
  assign launch    = start && ((state == ST_IDLE) || (state == ST_DONE));
  assign hit       = visited[pred_data];
  assign busy      = (state == ST_REQ) || (state == ST_WAIT);
  assign fifo_push = (state == ST_REQ) || ((state == ST_WAIT) && hit);
  assign fifo_din  = (state == ST_REQ) ? cur : pred_data;
  assign count_ext = (VW + 2)'(fifo_count);

  // A new walk flushes the FIFO through its synchronous reset.
  assign fifo_reset = reset && !launch;

  path_fifo #(
    .W     (VW),
    .DEPTH (DEPTH)
  ) u_path_fifo (
    .clk   (clk),
    .reset (fifo_reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // pred_addr is loaded one state ahead so the memory returns data during WAIT.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= ST_IDLE;
      cur         <= '0;
      start_latch <= '0;
      pred_addr   <= '0;
      visited     <= '0;
      ovf         <= 1'b0;
      irq         <= 1'b0;
    end else begin
      if (fifo_push && fifo_full) ovf <= 1'b1;
      if (status_rd) irq <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            cur         <= start_vertex;
            start_latch <= start_vertex;
            pred_addr   <= start_vertex;
            visited     <= '0;
            irq         <= 1'b0;
            state       <= ST_REQ;
          end
        end
        ST_REQ: begin
          visited[cur] <= 1'b1;
          state        <= ST_WAIT;
        end
        ST_WAIT: begin
          if (hit) begin
            irq   <= 1'b1;
            state <= ST_DONE;
          end else begin
            cur       <= pred_data;
            pred_addr <= pred_data;
            state     <= ST_REQ;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    rd_mux = '0;
    if (rd_en) begin
      case (address)
        ADDR_STATUS: begin
          rd_mux[31]     = busy;
          rd_mux[30]     = (state == ST_DONE);
          rd_mux[29]     = ovf;
          rd_mux[VW+1:0] = count_ext;
        end
        ADDR_POP: begin
          if (!fifo_empty) begin
            rd_mux[31]     = 1'b1;
            rd_mux[VW-1:0] = fifo_dout;
          end
        end
        ADDR_START: rd_mux[VW-1:0] = start_latch;
        default:    rd_mux = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) readdata <= '0;
    else        readdata <= rd_mux;
  end

endmodule
